// File: rtl/xor_gate.sv
// ============================================================================
// Module   : xor_gate
// Brief    : Bitwise XOR compare leaf with registered parity/popcount/count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xor_gate #(
    parameter  int WIDTH = 1,
    parameter  int CNT_W = 16,
    localparam int HD_W  = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_cnt,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  c,
    output logic [WIDTH-1:0]  c_q,
    output logic              parity,
    output logic [HD_W-1:0]   hd,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mis_cnt,
    output logic              cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] diff;
    logic [HD_W-1:0]  hd_d;
    logic             parity_d;
    logic             mismatch_d;
    logic [CNT_W-1:0] cnt_d;

    logic [WIDTH-1:0] c_q_q;
    logic             parity_q;
    logic [HD_W-1:0]  hd_q;
    logic             mismatch_q;
    logic [CNT_W-1:0] cnt_q;

    // Unmasked XOR so that X/Z on an input bit shows up on the matching c bit.
    assign diff       = a ^ b;
    assign parity_d   = ^diff;
    assign mismatch_d = |diff;

    always_comb begin
        hd_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hd_d = hd_d + HD_W'(diff[i]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (en && mismatch_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q_q      <= '0;
            parity_q   <= 1'b0;
            hd_q       <= '0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (en) begin
                c_q_q      <= diff;
                parity_q   <= parity_d;
                hd_q       <= hd_d;
                mismatch_q <= mismatch_d;
            end
            cnt_q <= cnt_d;
        end
    end

    assign c        = diff;
    assign c_q      = c_q_q;
    assign parity   = parity_q;
    assign hd       = hd_q;
    assign mismatch = mismatch_q;
    assign mis_cnt  = cnt_q;
    // Decoded from the counter register, so it rises with the saturating edge.
    assign cnt_sat  = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_xor_gate.sv
// ============================================================================
// Module   : tb_xor_gate
// Brief    : Directed + random checks of xor_gate at WIDTH=8/CNT_W=2 and WIDTH=1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xor_gate;

    logic       clk = 1'b0;
    logic       rst, en, clr_cnt;
    logic [7:0] a8, b8;
    logic       a1, b1;

    logic [7:0] c8, cq8;
    logic       par8, mis8, sat8;
    logic [3:0] hd8;
    logic [1:0] cnt8;

    logic       c1, cq1;
    logic       par1, mis1, sat1;
    logic [0:0] hd1;
    logic [15:0] cnt1;

    int checks   = 0;
    int failures = 0;

    // Reference state, kept as plain integers.
    int m_cq8, m_par8, m_hd8, m_mis8, m_cnt8;
    int m_cq1, m_par1, m_hd1, m_mis1, m_cnt1;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(8), .CNT_W(2)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .a(a8), .b(b8), .c(c8), .c_q(cq8), .parity(par8), .hd(hd8),
        .mismatch(mis8), .mis_cnt(cnt8), .cnt_sat(sat8)
    );

    xor_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .a(a1), .b(b1), .c(c1), .c_q(cq1), .parity(par1), .hd(hd1),
        .mismatch(mis1), .mis_cnt(cnt1), .cnt_sat(sat1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check c, then model the edge and check registers.
    task automatic step(input logic r, input logic e, input logic cl,
                        input logic [7:0] a8v, input logic [7:0] b8v,
                        input logic a1v, input logic b1v);
        int d8, d1;
        @(negedge clk);
        rst = r; en = e; clr_cnt = cl;
        a8 = a8v; b8 = b8v; a1 = a1v; b1 = b1v;
        #1;
        check("c8", 64'(c8), 64'(a8v ^ b8v));
        check("c1", 64'(c1), 64'(a1v ^ b1v));
        @(posedge clk);
        d8 = int'(a8v ^ b8v);
        d1 = int'(a1v ^ b1v);
        if (r) begin
            m_cq8 = 0; m_par8 = 0; m_hd8 = 0; m_mis8 = 0; m_cnt8 = 0;
            m_cq1 = 0; m_par1 = 0; m_hd1 = 0; m_mis1 = 0; m_cnt1 = 0;
        end else begin
            if (e) begin
                m_cq8 = d8; m_hd8 = $countones(d8); m_par8 = m_hd8 % 2; m_mis8 = (d8 != 0) ? 1 : 0;
                m_cq1 = d1; m_hd1 = $countones(d1); m_par1 = m_hd1 % 2; m_mis1 = (d1 != 0) ? 1 : 0;
            end
            if (cl) begin
                m_cnt8 = 0;
                m_cnt1 = 0;
            end else if (e) begin
                if (d8 != 0 && m_cnt8 < 3)     m_cnt8 = m_cnt8 + 1;
                if (d1 != 0 && m_cnt1 < 65535) m_cnt1 = m_cnt1 + 1;
            end
        end
        #1;
        check("cq8",  64'(cq8),  64'(m_cq8));
        check("par8", 64'(par8), 64'(m_par8));
        check("hd8",  64'(hd8),  64'(m_hd8));
        check("mis8", 64'(mis8), 64'(m_mis8));
        check("cnt8", 64'(cnt8), 64'(m_cnt8));
        check("sat8", 64'(sat8), 64'((m_cnt8 == 3) ? 1 : 0));
        check("cq1",  64'(cq1),  64'(m_cq1));
        check("par1", 64'(par1), 64'(m_par1));
        check("hd1",  64'(hd1),  64'(m_hd1));
        check("mis1", 64'(mis1), 64'(m_mis1));
        check("cnt1", 64'(cnt1), 64'(m_cnt1));
        check("sat1", 64'(sat1), 64'((m_cnt1 == 65535) ? 1 : 0));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr_cnt = 1'b0;
        a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;

        // Reset, with c live on the 1-bit gate throughout.
        step(1, 0, 0, 8'h00, 8'h00, 1, 0);
        step(1, 1, 1, 8'h3C, 8'hC3, 1, 0);

        // 1-bit truth table.
        step(0, 1, 0, 8'h00, 8'h00, 0, 0);
        step(0, 1, 0, 8'h00, 8'h00, 0, 1);
        step(0, 1, 0, 8'h00, 8'h00, 1, 0);
        step(0, 1, 0, 8'h00, 8'h00, 1, 1);
        check("w1_cnt_end", 64'(cnt1), 64'd2);

        // Mid-operation reset loses the count.
        step(1, 1, 0, 8'h00, 8'h00, 1, 0);
        check("rst_cnt1", 64'(cnt1), 64'd0);

        // 8-bit full difference.
        step(0, 1, 0, 8'hF0, 8'h0F, 0, 0);
        check("hd8_full", 64'(hd8), 64'd8);

        // Equal operands: no mismatch, counter holds.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hA5, 8'hA5, 1, 1);

        // Enable low: c follows, registers hold.
        step(0, 0, 0, 8'h12, 8'h34, 0, 1);
        step(0, 0, 0, 8'hFF, 8'h01, 1, 0);

        // Saturation of the 2-bit counter.
        step(1, 0, 0, 8'h00, 8'h00, 0, 0);
        step(0, 1, 0, 8'h01, 8'h00, 0, 1);
        check("sat_seq1", 64'(cnt8), 64'd1);
        step(0, 1, 0, 8'h80, 8'h00, 0, 1);
        check("sat_seq2", 64'(cnt8), 64'd2);
        step(0, 1, 0, 8'h55, 8'hAA, 0, 1);
        check("sat_seq3", 64'(cnt8), 64'd3);
        check("sat_flag", 64'(sat8), 64'd1);
        step(0, 1, 0, 8'h07, 8'h00, 0, 1);
        step(0, 1, 0, 8'h07, 8'h00, 0, 1);
        check("sat_hold", 64'(cnt8), 64'd3);

        // Clear beats increment; then count resumes.
        step(0, 1, 1, 8'h07, 8'h00, 0, 1);
        check("clr_cnt8", 64'(cnt8), 64'd0);
        step(0, 1, 0, 8'h07, 8'h00, 0, 1);
        check("after_clr", 64'(cnt8), 64'd1);

        // Clear with enable low.
        step(0, 0, 1, 8'h07, 8'h00, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 19) == 0),
                 8'($urandom), (($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom)),
                 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xor_gate.md
Name: xor_gate

Overview:
- Bitwise XOR comparator with a zero-latency combinational output and a registered statistics path: registered XOR result, parity, Hamming distance, and a saturating mismatch counter.
- Serves as the generic two-operand difference/compare leaf, used for equality checks, parity generation and error-bit counting.
- With WIDTH=1 it is a plain 2-input XOR gate on port c, plus the registered side outputs.

Parameters:
- WIDTH, 1: operand width in bits (legal range 1..64).
- CNT_W, 16: width of the mismatch-cycle counter (legal range 2..32).
- HD_W, derived as clog2(WIDTH+1) (min 1): width of the Hamming-distance output. Localparam, not overridable.

Ports:
- clk  in  1  single rising-edge clock for all registered outputs.
- rst  in  1  synchronous active-high reset.
- en  in  1  register-update enable for all registered outputs.
- clr_cnt  in  1  synchronous clear of the mismatch counter only.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c  out  WIDTH  combinational a ^ b.
- c_q  out  WIDTH  registered a ^ b.
- parity  out  1  registered reduction-XOR of (a ^ b).
- hd  out  HD_W  registered popcount of (a ^ b).
- mismatch  out  1  registered flag, asserted when (a ^ b) != 0.
- mis_cnt  out  CNT_W  saturating count of enabled cycles with a != b.
- cnt_sat  out  1  high while mis_cnt equals all-ones.

Behaviour:

Combinational output c:
- c = a ^ b, bit for bit, with zero latency.
- c is independent of clk, rst and en, and is valid during reset.
- Any X/Z on an input bit propagates to the corresponding c bit; no masking.

Reset:
- rst is sampled only on the rising edge of clk.
- When rst=1 at an edge: c_q=0, parity=0, hd=0, mismatch=0, mis_cnt=0, cnt_sat=0.
- rst has priority over en and clr_cnt.
- Reset asserted mid-operation clears all registers on the next edge; the count is lost.

Registered path (rst=0, en=1 at the edge):
- c_q <= a^b.
- parity <= ^(a^b).
- hd <= number of ones in (a^b).
- mismatch <= |(a^b).
- Latency is 1 cycle from inputs to all registered outputs.

Enable:
- rst=0, en=0: all registered outputs hold their value.
- mis_cnt also holds, except when clr_cnt is asserted.

Counter mis_cnt (rst=0):
- clr_cnt=1: mis_cnt <= 0, regardless of en. clr_cnt has priority over increment.
- Otherwise, with en=1 and (a^b)!=0: mis_cnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
- Any other case: mis_cnt holds.

Flag cnt_sat:
- cnt_sat = (mis_cnt == all-ones).
- It is derived from the register, so it asserts in the same cycle the counter reaches saturation.

Widths and encoding:
- hd is unsigned.
- The maximum hd value WIDTH always fits in HD_W bits.

Structure:
- No internal state beyond the listed registers.
- No state machine.
- No multicycle paths.

Test Plan:
- WIDTH=1, rst=0, en=1. Apply a,b = 00, 01, 10, 11, each held 200 ns -> c = 0, 1, 1, 0 immediately. c_q and mismatch match one clk edge later. mis_cnt ends at 2.
- Assert rst=1 for 1 cycle while a=1, b=0 -> c=1 throughout. After the edge: c_q=0, parity=0, hd=0, mismatch=0, mis_cnt=0.
- WIDTH=8, a=8'hF0, b=8'h0F, en=1 -> c=8'hFF at once. Next edge: c_q=8'hFF, hd=8, parity=0, mismatch=1.
- WIDTH=8, a=b=8'hA5 for 5 cycles -> c=0, hd=0, mismatch=0, mis_cnt unchanged. Then en=0 with a!=b -> c updates, but registers and mis_cnt hold.
- CNT_W=2, drive a!=b with en=1 for 5 cycles -> mis_cnt = 1, 2, 3, 3, 3. cnt_sat=1 from the cycle the count reaches 3.
- With mis_cnt=3, assert clr_cnt=1 and en=1 with a!=b -> mis_cnt=0 and cnt_sat=0 next edge. Then clr_cnt=0 -> mis_cnt=1.
